// File: rtl/lsu_pkg.sv
// ============================================================================
// lsu_pkg : opcode, func3 and state definitions shared by the LSU files
// Rev 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [4:0] R_type  = 5'b01100;
  localparam logic [4:0] I_Comp  = 5'b00100;
  localparam logic [4:0] I_Load  = 5'b00000;
  localparam logic [4:0] Store   = 5'b01000;
  localparam logic [4:0] B_type  = 5'b11000;
  localparam logic [4:0] J_jal   = 5'b11011;
  localparam logic [4:0] I_jalr  = 5'b11001;
  localparam logic [4:0] U_lui   = 5'b01101;
  localparam logic [4:0] U_auipc = 5'b00101;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_e;

  // Opcodes whose result lands in the register file (B-type and unknown do not).
  function automatic logic writes_rd(input logic [4:0] op);
    logic r;
    case (op)
      R_type, I_Comp, J_jal, I_jalr, U_lui, U_auipc: r = 1'b1;
      default:                                       r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// lsu_align : byte-lane strobe/replication for stores, extraction/extension
//             for loads, and access legality checks
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_func3,
  input  logic [1:0]  i_offset,
  input  logic        i_is_store,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data,
  output logic        o_misaligned,
  output logic        o_illegal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_offset)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_load_data = 32'h0;
    case (i_func3)
      LB:      o_load_data = {{24{w_byte[7]}}, w_byte};
      LH:      o_load_data = {{16{w_half[15]}}, w_half};
      LW:      o_load_data = i_rdata;
      LBU:     o_load_data = {24'h0, w_byte};
      LHU:     o_load_data = {16'h0, w_half};
      default: o_load_data = 32'h0;
    endcase
  end

  always_comb begin
    o_wstrb = 4'b0000;
    o_wdata = 32'h0;
    case (i_func3)
      SB: begin
        o_wstrb = 4'b0001 << i_offset;
        o_wdata = {4{i_store_data[7:0]}};
      end
      SH: begin
        o_wstrb = 4'b0011 << i_offset;
        o_wdata = {2{i_store_data[15:0]}};
      end
      SW: begin
        o_wstrb = 4'b1111;
        o_wdata = i_store_data;
      end
      default: begin
        o_wstrb = 4'b0000;
        o_wdata = 32'h0;
      end
    endcase
  end

  // func3[1:0] encodes the access size for both loads and stores.
  always_comb begin
    o_misaligned = ((i_func3[1:0] == 2'b01) && i_offset[0]) ||
                   ((i_func3[1:0] == 2'b10) && (i_offset != 2'b00));
    o_illegal = 1'b1;
    if (i_is_store) begin
      case (i_func3)
        SB, SH, SW: o_illegal = 1'b0;
        default:    o_illegal = 1'b1;
      endcase
    end else begin
      case (i_func3)
        LB, LH, LW, LBU, LHU: o_illegal = 1'b0;
        default:              o_illegal = 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/lsu_stage.sv
// ============================================================================
// lsu_stage : memory stage with single-outstanding req/ack data port and a
//             registered one-beat writeback per retired instruction
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu_stage
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [4:0]      ex_opcode,
  input  logic [2:0]      ex_func3,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [4:0]      ex_rd,
  output logic            stall_o,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_wstrb,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            mem_err
);

  lsu_state_e      r_state;
  logic            r_req;
  logic            r_we;
  logic [XLEN-1:0] r_addr;
  logic [3:0]      r_wstrb;
  logic [XLEN-1:0] r_wdata;
  logic [2:0]      r_func3;
  logic [1:0]      r_off;
  logic [4:0]      r_rd;
  logic            r_is_load;
  logic            r_wb_valid;
  logic            r_wb_we;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;
  logic            r_mem_err;

  logic            w_busy;
  logic            w_is_load;
  logic            w_is_store;
  logic            w_is_mem;
  logic [2:0]      w_al_func3;
  logic [1:0]      w_al_off;
  logic            w_al_store;
  logic [3:0]      w_wstrb;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_load_data;
  logic            w_misaligned;
  logic            w_illegal;
  logic            w_bad;
  logic            w_accept_mem;

  assign w_busy     = (r_state == BUSY);
  assign w_is_load  = (ex_opcode == I_Load);
  assign w_is_store = (ex_opcode == Store);
  assign w_is_mem   = w_is_load || w_is_store;

  // One aligner: IDLE looks at the incoming request, BUSY at the latched one.
  assign w_al_func3 = w_busy ? r_func3    : ex_func3;
  assign w_al_off   = w_busy ? r_off      : ex_alu_out[1:0];
  assign w_al_store = w_busy ? !r_is_load : w_is_store;

  lsu_align u_align (
    .i_func3      (w_al_func3),
    .i_offset     (w_al_off),
    .i_is_store   (w_al_store),
    .i_store_data (ex_store_data),
    .i_rdata      (dmem_rdata),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal)
  );

  assign w_bad        = w_misaligned || w_illegal;
  assign w_accept_mem = ex_valid && w_is_mem && !w_bad;

  assign stall_o = w_busy ? !dmem_ack : w_accept_mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wstrb    <= 4'b0000;
      r_wdata    <= '0;
      r_func3    <= 3'b000;
      r_off      <= 2'b00;
      r_rd       <= 5'd0;
      r_is_load  <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_mem_err  <= 1'b0;
      if (!w_busy) begin
        if (ex_valid) begin
          if (w_is_mem && w_bad) begin
            r_wb_valid <= 1'b1;
            r_wb_we    <= 1'b0;
            r_wb_rd    <= ex_rd;
            r_wb_data  <= ex_alu_out;
            r_mem_err  <= 1'b1;
          end else if (w_is_mem) begin
            r_state   <= BUSY;
            r_req     <= 1'b1;
            r_we      <= w_is_store;
            r_addr    <= {ex_alu_out[XLEN-1:2], 2'b00};
            r_wstrb   <= w_is_store ? w_wstrb : 4'b0000;
            r_wdata   <= w_is_store ? w_wdata : '0;
            r_func3   <= ex_func3;
            r_off     <= ex_alu_out[1:0];
            r_rd      <= ex_rd;
            r_is_load <= w_is_load;
          end else begin
            r_wb_valid <= 1'b1;
            r_wb_we    <= writes_rd(ex_opcode) && (ex_rd != 5'd0);
            r_wb_rd    <= ex_rd;
            r_wb_data  <= ex_alu_out;
          end
        end
      end else if (dmem_ack) begin
        r_state    <= IDLE;
        r_req      <= 1'b0;
        r_wb_valid <= 1'b1;
        r_wb_we    <= r_is_load && (r_rd != 5'd0);
        r_wb_rd    <= r_rd;
        if (r_is_load) begin
          r_wb_data <= w_load_data;
        end
      end
    end
  end

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wstrb = r_wstrb;
  assign dmem_wdata = r_wdata;
  assign wb_valid   = r_wb_valid;
  assign wb_we      = r_wb_we;
  assign wb_rd      = r_wb_rd;
  assign wb_data    = r_wb_data;
  assign mem_err    = r_mem_err;

endmodule

`default_nettype wire

// File: tb/tb_lsu_stage.sv
// ============================================================================
// tb_lsu_stage : vector table, hand sequences and randomized model checks
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [4:0]  ex_opcode = 5'd0;
  logic [2:0]  ex_func3 = 3'd0;
  logic [31:0] ex_alu_out = 32'd0;
  logic [31:0] ex_store_data = 32'd0;
  logic [4:0]  ex_rd = 5'd0;
  logic        stall_o;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_err;

  int n_cmp = 0;
  int n_err = 0;

  lsu_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_func3(ex_func3), .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .stall_o(stall_o), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          dly;
    logic        mem;
    logic        mwe;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        wb_we;
    logic [31:0] wb_data;
    logic        err;
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] op, input logic [2:0] f3,
      input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
      input logic [31:0] rdata, input int dly, input logic mem, input logic mwe,
      input logic [3:0] wstrb, input logic [31:0] wdata, input logic wbwe,
      input logic [31:0] wbdata, input logic err);
    vec_t v;
    v.op = op; v.f3 = f3; v.alu = alu; v.sd = sd; v.rd = rd; v.rdata = rdata;
    v.dly = dly; v.mem = mem; v.mwe = mwe; v.wstrb = wstrb; v.wdata = wdata;
    v.wb_we = wbwe; v.wb_data = wbdata; v.err = err;
    return v;
  endfunction

  // Reference: derived from access size, lane offset and the legal func3 lists.
  function automatic vec_t model(input vec_t v);
    vec_t e = v;
    int size, o;
    bit legal;
    logic [31:0] mask, val;
    e.mem = 0; e.mwe = 0; e.wstrb = 0; e.wdata = 0; e.err = 0;
    e.wb_we = 0; e.wb_data = v.alu;
    o = int'(v.alu % 4);
    if (v.op == 5'b00000 || v.op == 5'b01000) begin
      size = 1 << int'(v.f3 % 4);
      if (v.op == 5'b00000) legal = (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      else                  legal = (v.f3 inside {3'd0, 3'd1, 3'd2});
      if (!legal || (o % size) != 0) begin
        e.err = 1;
      end else if (v.op == 5'b01000) begin
        e.mem = 1; e.mwe = 1;
        e.wstrb = 4'(((1 << size) - 1) << o);
        if (size == 1)      e.wdata = (v.sd & 32'hFF) * 32'h01010101;
        else if (size == 2) e.wdata = (v.sd & 32'hFFFF) * 32'h00010001;
        else                e.wdata = v.sd;
      end else begin
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 1);
        val  = (v.rdata >> (8 * o)) & mask;
        if (v.f3 < 3'd4 && size < 4 && (val & ((mask >> 1) + 1)) != 0) val = val | ~mask;
        e.mem = 1; e.wb_we = (v.rd != 0); e.wb_data = val;
      end
    end else begin
      e.wb_we = (v.op inside {5'b01100, 5'b00100, 5'b11011, 5'b11001, 5'b01101, 5'b00101})
                && (v.rd != 0);
    end
    return e;
  endfunction

  task automatic do_op(input vec_t v, input string tag);
    @(negedge clk);
    ex_opcode = v.op; ex_func3 = v.f3; ex_alu_out = v.alu;
    ex_store_data = v.sd; ex_rd = v.rd; ex_valid = 1'b1;
    #1 check({tag, ".stall_in"}, 32'(stall_o), 32'(v.mem));
    @(negedge clk);
    ex_valid = 1'b0;
    if (v.mem) begin
      for (int k = 0; k <= v.dly; k++) begin
        check({tag, ".req"}, 32'(dmem_req), 32'd1);
        check({tag, ".addr"}, dmem_addr, {v.alu[31:2], 2'b00});
        check({tag, ".we"}, 32'(dmem_we), 32'(v.mwe));
        if (v.mwe) begin
          check({tag, ".wstrb"}, 32'(dmem_wstrb), 32'(v.wstrb));
          check({tag, ".wdata"}, dmem_wdata, v.wdata);
        end
        check({tag, ".wbv_busy"}, 32'(wb_valid), 32'd0);
        if (k == v.dly) begin
          dmem_ack = 1'b1; dmem_rdata = v.rdata;
          #1 check({tag, ".stall_ack"}, 32'(stall_o), 32'd0);
        end else begin
          check({tag, ".stall_busy"}, 32'(stall_o), 32'd1);
          dmem_rdata = $urandom;
          @(negedge clk);
        end
      end
      @(negedge clk);
      dmem_ack = 1'b0; dmem_rdata = $urandom;
    end
    check({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
    check({tag, ".wb_we"}, 32'(wb_we), 32'(v.wb_we));
    check({tag, ".mem_err"}, 32'(mem_err), 32'(v.err));
    check({tag, ".req_after"}, 32'(dmem_req), 32'd0);
    if (v.wb_we || (!v.mem && !v.err)) begin
      check({tag, ".wb_data"}, wb_data, v.wb_data);
      check({tag, ".wb_rd"}, 32'(wb_rd), 32'(v.rd));
    end
  endtask

  initial begin
    vec_t v;
    logic [4:0] nonmem[9];
    nonmem = '{5'b01100, 5'b00100, 5'b11000, 5'b11011, 5'b11001,
               5'b01101, 5'b00101, 5'b11111, 5'b00011};

    //          op        f3    alu           sd            rd  rdata        dly mem mwe wstrb    wdata         wbwe wbdata        err
    tbl[0]  = mk(5'b01100, 3'd0, 32'h10,       32'h0,        5,  32'h0,        0, 0, 0, 4'b0000, 32'h0,        1, 32'h10,       0);
    tbl[1]  = mk(5'b01000, 3'd0, 32'h1003,     32'hAB,       0,  32'h0,        3, 1, 1, 4'b1000, 32'hABABABAB, 0, 32'h0,        0);
    tbl[2]  = mk(5'b00000, 3'd4, 32'h2002,     32'h0,        6,  32'h0080FF00, 1, 1, 0, 4'b0000, 32'h0,        1, 32'h00000080, 0);
    tbl[3]  = mk(5'b00000, 3'd0, 32'h2002,     32'h0,        6,  32'h00800000, 0, 1, 0, 4'b0000, 32'h0,        1, 32'hFFFFFF80, 0);
    tbl[4]  = mk(5'b00000, 3'd4, 32'h2002,     32'h0,        6,  32'h00800000, 2, 1, 0, 4'b0000, 32'h0,        1, 32'h00000080, 0);
    tbl[5]  = mk(5'b00000, 3'd1, 32'h3001,     32'h0,        7,  32'h0,        0, 0, 0, 4'b0000, 32'h0,        0, 32'h0,        1);
    tbl[6]  = mk(5'b00000, 3'd2, 32'h4000,     32'h0,        0,  32'hDEADBEEF, 1, 1, 0, 4'b0000, 32'h0,        0, 32'h0,        0);
    tbl[7]  = mk(5'b01000, 3'd1, 32'h1002,     32'h1234CAFE, 0,  32'h0,        0, 1, 1, 4'b1100, 32'hCAFECAFE, 0, 32'h0,        0);
    tbl[8]  = mk(5'b01000, 3'd2, 32'h1004,     32'h89ABCDEF, 0,  32'h0,        1, 1, 1, 4'b1111, 32'h89ABCDEF, 0, 32'h0,        0);
    tbl[9]  = mk(5'b00000, 3'd1, 32'h2002,     32'h0,        9,  32'h80011234, 0, 1, 0, 4'b0000, 32'h0,        1, 32'hFFFF8001, 0);
    tbl[10] = mk(5'b00000, 3'd5, 32'h2002,     32'h0,        9,  32'h80011234, 0, 1, 0, 4'b0000, 32'h0,        1, 32'h00008001, 0);
    tbl[11] = mk(5'b00000, 3'd0, 32'h2001,     32'h0,        10, 32'h00007F00, 0, 1, 0, 4'b0000, 32'h0,        1, 32'h0000007F, 0);
    tbl[12] = mk(5'b00000, 3'd3, 32'h4000,     32'h0,        11, 32'h0,        0, 0, 0, 4'b0000, 32'h0,        0, 32'h0,        1);
    tbl[13] = mk(5'b01000, 3'd4, 32'h1000,     32'h55,       0,  32'h0,        0, 0, 0, 4'b0000, 32'h0,        0, 32'h0,        1);
    tbl[14] = mk(5'b01000, 3'd2, 32'h1002,     32'h55,       0,  32'h0,        0, 0, 0, 4'b0000, 32'h0,        0, 32'h0,        1);
    tbl[15] = mk(5'b11000, 3'd0, 32'h40,       32'h0,        3,  32'h0,        0, 0, 0, 4'b0000, 32'h0,        0, 32'h40,       0);
    tbl[16] = mk(5'b01100, 3'd0, 32'h77,       32'h0,        0,  32'h0,        0, 0, 0, 4'b0000, 32'h0,        0, 32'h77,       0);
    tbl[17] = mk(5'b01101, 3'd0, 32'hABCDE000, 32'h0,        31, 32'h0,        0, 0, 0, 4'b0000, 32'h0,        1, 32'hABCDE000, 0);
    tbl[18] = mk(5'b11111, 3'd0, 32'h5,        32'h0,        4,  32'h0,        0, 0, 0, 4'b0000, 32'h0,        0, 32'h5,        0);
    tbl[19] = mk(5'b11001, 3'd0, 32'h104,      32'h0,        1,  32'h0,        0, 0, 0, 4'b0000, 32'h0,        1, 32'h104,      0);

    repeat (3) @(negedge clk);
    check("rst.stall", 32'(stall_o), 32'd0);
    check("rst.req", 32'(dmem_req), 32'd0);
    check("rst.we", 32'(dmem_we), 32'd0);
    check("rst.addr", dmem_addr, 32'd0);
    check("rst.wstrb", 32'(dmem_wstrb), 32'd0);
    check("rst.wdata", dmem_wdata, 32'd0);
    check("rst.wb_valid", 32'(wb_valid), 32'd0);
    check("rst.wb_we", 32'(wb_we), 32'd0);
    check("rst.wb_rd", 32'(wb_rd), 32'd0);
    check("rst.wb_data", wb_data, 32'd0);
    check("rst.mem_err", 32'(mem_err), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) do_op(tbl[i], $sformatf("vec%0d", i));

    // An instruction offered in the ack cycle retires one cycle after the load.
    v = mk(5'b00000, 3'd2, 32'h5000, 32'h0, 7, 32'h0, 0, 0, 0, 4'b0, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    ex_opcode = v.op; ex_func3 = v.f3; ex_alu_out = v.alu; ex_rd = v.rd; ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    check("bub.req", 32'(dmem_req), 32'd1);
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    ex_opcode = 5'b01100; ex_func3 = 3'd0; ex_alu_out = 32'h99; ex_rd = 5'd3; ex_valid = 1'b1;
    #1 check("bub.stall_ack", 32'(stall_o), 32'd0);
    @(negedge clk);
    dmem_ack = 1'b0;
    check("bub.ld_valid", 32'(wb_valid), 32'd1);
    check("bub.ld_rd", 32'(wb_rd), 32'd7);
    check("bub.ld_data", wb_data, 32'h12345678);
    @(negedge clk);
    ex_valid = 1'b0;
    check("bub.add_valid", 32'(wb_valid), 32'd1);
    check("bub.add_rd", 32'(wb_rd), 32'd3);
    check("bub.add_data", wb_data, 32'h99);
    check("bub.add_we", 32'(wb_we), 32'd1);
    @(negedge clk);
    check("idle.wb_valid", 32'(wb_valid), 32'd0);
    check("idle.wb_data_hold", wb_data, 32'h99);
    check("idle.wb_rd_hold", 32'(wb_rd), 32'd3);

    // Reset while BUSY, then a stray ack.
    @(negedge clk);
    ex_opcode = 5'b01000; ex_func3 = 3'd2; ex_alu_out = 32'h6000; ex_store_data = 32'h1; ex_rd = 0;
    ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    check("rma.req_before", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("rma.req_async", 32'(dmem_req), 32'd0);
    check("rma.stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("rma.late_ack_wbv", 32'(wb_valid), 32'd0);
    check("rma.late_ack_req", 32'(dmem_req), 32'd0);
    do_op(tbl[0], "rma.after");

    for (int i = 0; i < 80; i++) begin
      int r;
      r = $urandom_range(0, 9);
      v.op = (r < 3) ? 5'b00000 : (r < 6) ? 5'b01000 : nonmem[$urandom_range(0, 8)];
      v.f3 = 3'($urandom_range(0, 7));
      v.alu = $urandom;
      if ($urandom_range(0, 1) == 1) v.alu[1:0] = 2'b00;
      v.sd = $urandom;
      v.rd = 5'($urandom_range(0, 31));
      v.rdata = $urandom;
      v.dly = $urandom_range(0, 3);
      do_op(model(v), $sformatf("rnd%0d", i));
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
